// File: rtl/button_sequence_capture.sv
// rtl/button_sequence_capture.sv - debounced KEY capture into a packed 2-bit symbol sequence
// Symbols are accepted one press at a time; a release must be seen between presses.
module button_sequence_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SYMBOLS     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     button_1,
  input  logic                     button_2,
  input  logic                     button_3,
  input  logic                     button_4,
  input  logic                     start,
  input  logic [4:0]               target_len,
  input  logic [2*MAX_SYMBOLS-1:0] expected_seq,
  output logic                     symbol_valid,
  output logic [1:0]               symbol,
  output logic [5:0]               input_count,
  output logic [2*MAX_SYMBOLS-1:0] entered_seq,
  output logic                     done,
  output logic                     match,
  output logic                     multi_press,
  output logic                     led_1,
  output logic                     led_2,
  output logic                     led_3,
  output logic                     led_4
);

  localparam int SW    = 2 * MAX_SYMBOLS;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]       MAX_CNT  = 6'(MAX_SYMBOLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE_WAIT,
    S_PRESS_WAIT,
    S_HOLD,
    S_COMPLETE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        lbtn_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        count_q, count_d;
  logic [5:0]        tlen_q, tlen_d;
  logic [SW-1:0]     entered_q, entered_d;
  logic [1:0]        symbol_q, symbol_d;
  logic              symbol_valid_q, symbol_valid_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              multi_q, multi_d;

  logic [3:0]        btn;
  logic [2:0]        ones;
  logic              one_hot;
  logic              capturing;
  logic [1:0]        btn_sym;
  logic [5:0]        tlen_clamped;
  logic [5:0]        count_inc;
  logic [SW-1:0]     entered_ins;
  logic [SW-1:0]     seq_mask;

  assign btn       = ~sync2_q;
  assign ones      = {2'b00, btn[0]} + {2'b00, btn[1]} + {2'b00, btn[2]} + {2'b00, btn[3]};
  assign one_hot   = (ones == 3'd1);
  assign capturing = (state_q == S_RELEASE_WAIT) || (state_q == S_PRESS_WAIT) ||
                     (state_q == S_HOLD);
  assign tlen_clamped = (6'(target_len) > MAX_CNT) ? MAX_CNT : 6'(target_len);
  assign count_inc    = count_q + 6'd1;

  always_comb begin
    btn_sym = 2'd3;
    case (btn)
      4'b0001: btn_sym = 2'd0;
      4'b0010: btn_sym = 2'd1;
      4'b0100: btn_sym = 2'd2;
      default: btn_sym = 2'd3;
    endcase
  end

  // Entered sequence with the current symbol dropped into slot count_q, and the
  // comparison window covering only the first tlen_q symbols.
  always_comb begin
    entered_ins = entered_q;
    seq_mask    = '0;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (count_q == 6'(i)) entered_ins[2*i +: 2] = btn_sym;
      if (6'(i) < tlen_q)   seq_mask[2*i +: 2]    = 2'b11;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    count_d        = count_q;
    tlen_d         = tlen_q;
    entered_d      = entered_q;
    symbol_d       = symbol_q;
    symbol_valid_d = 1'b0;
    done_d         = done_q;
    match_d        = match_q;
    multi_d        = capturing && (ones > 3'd1);

    case (state_q)
      S_IDLE: ;
      S_RELEASE_WAIT, S_HOLD: begin
        if (btn != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_PRESS_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESS_WAIT: begin
        if (!one_hot || (btn != lbtn_q)) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          symbol_valid_d = 1'b1;
          symbol_d       = btn_sym;
          entered_d      = entered_ins;
          count_d        = count_inc;
          if (count_inc == tlen_q) begin
            state_d = S_COMPLETE;
            done_d  = 1'b1;
            match_d = (((entered_ins ^ expected_seq) & seq_mask) == '0);
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMPLETE: ;
      default: state_d = S_IDLE;
    endcase

    // start overrides whatever the state machine decided this cycle
    if (start) begin
      cnt_d          = '0;
      count_d        = '0;
      entered_d      = '0;
      symbol_valid_d = 1'b0;
      tlen_d         = tlen_clamped;
      if (tlen_clamped == 6'd0) begin
        state_d = S_COMPLETE;
        done_d  = 1'b1;
        match_d = 1'b1;
      end else begin
        state_d = S_RELEASE_WAIT;
        done_d  = 1'b0;
        match_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q        <= 4'hF;
      sync2_q        <= 4'hF;
      lbtn_q         <= 4'h0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      count_q        <= '0;
      tlen_q         <= '0;
      entered_q      <= '0;
      symbol_q       <= '0;
      symbol_valid_q <= 1'b0;
      done_q         <= 1'b0;
      match_q        <= 1'b0;
      multi_q        <= 1'b0;
    end else begin
      sync1_q        <= {button_4, button_3, button_2, button_1};
      sync2_q        <= sync1_q;
      lbtn_q         <= btn;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      count_q        <= count_d;
      tlen_q         <= tlen_d;
      entered_q      <= entered_d;
      symbol_q       <= symbol_d;
      symbol_valid_q <= symbol_valid_d;
      done_q         <= done_d;
      match_q        <= match_d;
      multi_q        <= multi_d;
    end
  end

  assign symbol_valid = symbol_valid_q;
  assign symbol       = symbol_q;
  assign input_count  = count_q;
  assign entered_seq  = entered_q;
  assign done         = done_q;
  assign match        = match_q;
  assign multi_press  = multi_q;
  assign led_1        = (state_q == S_HOLD) && (symbol_q == 2'd0);
  assign led_2        = (state_q == S_HOLD) && (symbol_q == 2'd1);
  assign led_3        = (state_q == S_HOLD) && (symbol_q == 2'd2);
  assign led_4        = (state_q == S_HOLD) && (symbol_q == 2'd3);

endmodule
